mod_n_down_counter: RTL

- Loadable mod-N down-counter: counts from top (M-1) down to 0, then reloads top.
- Emits a registered one-cycle borrow pulse on each wrap, for cascading and period timing.
- The modulus can be changed at runtime. The new value goes into a shadow register and is applied only at a wrap or a clear, so a period is never truncated.
- Companion to the team's up-counting mod-N counter: same N/LENGTH convention, opposite count direction, used for timeouts and prescalers.

---
 rtl/mod_n_down_counter.sv | 85 ++++++++
 1 files changed

// File: rtl/mod_n_down_counter.sv
// Loadable mod-N down-counter with a shadowed, wrap-synchronised modulus.
// Emits a registered one-cycle borrow pulse after each wrap to zero.
module mod_n_down_counter #(
    parameter int N      = 6,
    parameter int LENGTH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic              load,
    input  logic [LENGTH-1:0] load_val,
    input  logic              top_wr,
    input  logic [LENGTH-1:0] top_val,
    output logic [LENGTH-1:0] counter,
    output logic [LENGTH-1:0] top_active,
    output logic              borrow,
    output logic              zero
);

    generate
        if (N < 1 || N > (1 << LENGTH)) begin : g_bad_n
            $error("mod_n_down_counter: N must lie in 1..2**LENGTH");
        end
    endgenerate

    localparam logic [LENGTH-1:0] RST_TOP = LENGTH'(N - 1);

    logic [LENGTH-1:0] shadow;
    logic              pend;

    function automatic logic [LENGTH-1:0] sat_to_top(input logic [LENGTH-1:0] v,
                                                     input logic [LENGTH-1:0] top);
        return (v > top) ? top : v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter    <= RST_TOP;
            top_active <= RST_TOP;
            shadow     <= RST_TOP;
            pend       <= 1'b0;
            borrow     <= 1'b0;
        end else begin
            borrow <= 1'b0;
            if (top_wr) begin
                shadow <= top_val;
                pend   <= 1'b1;
            end
            if (clr) begin
                // A same-cycle write bypasses the shadow so clear restarts on the newest top.
                if (top_wr) begin
                    top_active <= top_val;
                    counter    <= top_val;
                    pend       <= 1'b0;
                end else if (pend) begin
                    top_active <= shadow;
                    counter    <= shadow;
                    pend       <= 1'b0;
                end else begin
                    counter <= top_active;
                end
            end else if (load) begin
                counter <= sat_to_top(load_val, top_active);
            end else if (en) begin
                if (counter != '0) begin
                    counter <= counter - 1'b1;
                end else begin
                    borrow <= 1'b1;
                    // A write landing on the wrap edge stays pending for the following wrap.
                    if (pend) begin
                        top_active <= shadow;
                        counter    <= shadow;
                        pend       <= top_wr;
                    end else begin
                        counter <= top_active;
                    end
                end
            end
        end
    end

    assign zero = (counter == '0);

endmodule
